// File: rtl/usbf_dma_pkg.sv
// Shared types and defaults for the USB function DMA arbiter.
// Holds the arbiter state encoding, default endpoint count and burst length,
// and the fixed field widths used by the arbiter and its round-robin picker.
package usbf_dma_pkg;

  localparam int unsigned NUM_EP_DEF    = 16;
  localparam int unsigned BURST_MAX_DEF = 16;
  localparam int unsigned EP_MAX        = 16;  // widest endpoint vector supported
  localparam int unsigned EP_W          = 4;   // width of an encoded endpoint number
  localparam int unsigned CNT_W         = 8;   // width of the per-grant word counter

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/usbf_rr_pick.sv
// Round-robin selector: finds the first set request bit searching upward
// from last+1 and wrapping at NUM_EP.
// Ports:
//   req   - request vector, one bit per endpoint
//   last  - endpoint granted most recently (lowest priority on this search)
//   idx   - encoded index of the chosen endpoint (0 when none)
//   valid - at least one request bit is set
module usbf_rr_pick
  import usbf_dma_pkg::*;
#(
  parameter int unsigned NUM_EP = NUM_EP_DEF
) (
  input  logic [NUM_EP-1:0] req,
  input  logic [EP_W-1:0]   last,
  output logic [EP_W-1:0]   idx,
  output logic              valid
);

  localparam int unsigned CW = EP_W + 1;

  logic [EP_MAX-1:0] req_ext;
  logic [CW-1:0]     cand;

  // Walk last+1 .. last+NUM_EP modulo NUM_EP; the first hit wins.
  always_comb begin
    req_ext = EP_MAX'(req);
    cand    = '0;
    idx     = '0;
    valid   = 1'b0;
    for (int i = 1; i <= int'(NUM_EP); i++) begin
      cand = CW'(last) + CW'(i);
      if (cand >= CW'(NUM_EP)) begin
        cand = cand - CW'(NUM_EP);
      end
      if (!valid && req_ext[cand[EP_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[EP_W-1:0];
      end
    end
  end

endmodule

// File: rtl/usbf_dma_arb.sv
// DMA arbiter for the USB function core: grants the system DMA controller to
// one endpoint register file at a time, round-robin, with a burst limit.
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   ep_dma_req   - per-endpoint DMA request
//   ep_dma_ack   - per-endpoint word acknowledge (dma_ack steered to the grantee)
//   dma_req      - request to the DMA controller, high for the whole grant
//   dma_ep       - encoded granted endpoint, qualified by dma_req
//   dma_ack      - one-cycle pulse per word moved by the DMA controller
//   dma_ack_err  - pulses when dma_ack arrives with no grant active
module usbf_dma_arb
  import usbf_dma_pkg::*;
#(
  parameter int unsigned NUM_EP    = NUM_EP_DEF,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_EP-1:0] ep_dma_req,
  output logic [NUM_EP-1:0] ep_dma_ack,
  output logic              dma_req,
  output logic [EP_W-1:0]   dma_ep,
  input  logic              dma_ack,
  output logic              dma_ack_err
);

  localparam int unsigned CW1 = CNT_W + 1;

  state_t            state;
  state_t            state_next;
  logic [EP_W-1:0]   sel;
  logic [EP_W-1:0]   last;
  logic [CNT_W-1:0]  cnt;
  logic [EP_W-1:0]   pick_idx;
  logic              pick_valid;
  logic [EP_MAX-1:0] req_ext;
  logic [EP_MAX-1:0] ack_vec;
  logic              req_sel;
  logic              burst_done;

  usbf_rr_pick #(
    .NUM_EP (NUM_EP)
  ) u_pick (
    .req   (ep_dma_req),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Grantee's own request and burst-limit detection for this cycle's ack.
  always_comb begin
    req_ext    = EP_MAX'(ep_dma_req);
    req_sel    = req_ext[sel];
    burst_done = dma_ack && ((CW1'(cnt) + CW1'(1)) >= CW1'(BURST_MAX));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (pick_valid) state_next = ST_GRANT;
      ST_GRANT:   if (!req_sel || burst_done) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Grant bookkeeping and the registered dma_req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= '0;
      last    <= EP_W'(NUM_EP - 1);
      cnt     <= '0;
      dma_req <= 1'b0;
    end else begin
      dma_req <= (state_next == ST_GRANT);
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            sel <= pick_idx;
            cnt <= '0;
          end
        end
        ST_GRANT: begin
          // Saturate rather than wrap.
          if (dma_ack && (cnt < CNT_W'(BURST_MAX))) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: last <= sel;
        default: ;
      endcase
    end
  end

  assign dma_ep = sel;

  // Zero-latency ack steering; a stray ack outside a grant is flagged instead.
  always_comb begin
    ack_vec     = '0;
    dma_ack_err = 1'b0;
    if (!rst) begin
      if (state == ST_GRANT) begin
        ack_vec[sel] = dma_ack;
      end else begin
        dma_ack_err = dma_ack;
      end
    end
    ep_dma_ack = NUM_EP'(ack_vec);
  end

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Directed testbench for usbf_dma_arb. Instance a uses the default burst
// limit (16); instance b uses BURST_MAX=2. Inputs change and outputs are
// sampled just after the falling edge, away from the active rising edge.
module tb_usbf_dma_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_a, ep_ack_a, req_b, ep_ack_b;
  logic        ack_a, dma_req_a, err_a, ack_b, dma_req_b, err_b;
  logic [3:0]  dma_ep_a, dma_ep_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  usbf_dma_arb #(.NUM_EP(16), .BURST_MAX(16)) dut_a (
    .clk(clk), .rst(rst), .ep_dma_req(req_a), .ep_dma_ack(ep_ack_a),
    .dma_req(dma_req_a), .dma_ep(dma_ep_a), .dma_ack(ack_a), .dma_ack_err(err_a)
  );

  usbf_dma_arb #(.NUM_EP(16), .BURST_MAX(2)) dut_b (
    .clk(clk), .rst(rst), .ep_dma_req(req_b), .ep_dma_ack(ep_ack_b),
    .dma_req(dma_req_b), .dma_ep(dma_ep_b), .dma_ack(ack_b), .dma_ack_err(err_b)
  );

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant_a(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      next_cyc();
      if (dma_req_a) seen = 1'b1;
    end
  endtask

  task automatic wait_grant_b(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      next_cyc();
      if (dma_req_b) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = '0; req_b = '0; ack_a = 1'b1; ack_b = 1'b0;
    #2;
    checks++; if (dma_req_a !== 1'b0) begin errors++; $display("FAIL reset_dma_req got %0b exp 0", dma_req_a); end
    checks++; if (ep_ack_a !== 16'h0) begin errors++; $display("FAIL reset_ep_ack got %0h exp 0", ep_ack_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %0b exp 0", err_a); end
    checks++; if (dma_ep_a !== 4'd0) begin errors++; $display("FAIL reset_dma_ep got %0d exp 0", dma_ep_a); end
    ack_a = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit seen;
    next_cyc();
    req_a = 16'h0004;
    wait_grant_a(6, seen);
    checks++; if (!seen) begin errors++; $display("FAIL single_grant got no grant exp dma_req=1"); end
    checks++; if (dma_ep_a !== 4'd2) begin errors++; $display("FAIL single_ep got %0d exp 2", dma_ep_a); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cyc();
      ack_a = 1'b1;
      req_a = (k == 1) ? 16'h0006 : 16'h0004;  // unrelated request mid-grant
      #1;
      checks++; if (ep_ack_a !== 16'h0004) begin errors++; $display("FAIL single_ack%0d got %0h exp 0004", k, ep_ack_a); end
      checks++; if (dma_ep_a !== 4'd2) begin errors++; $display("FAIL single_hold%0d got %0d exp 2", k, dma_ep_a); end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL single_err%0d got %0b exp 0", k, err_a); end
    end
    next_cyc();
    ack_a = 1'b0; req_a = 16'h0000;
    #1;
    checks++; if (dma_req_a !== 1'b1) begin errors++; $display("FAIL single_drop_cycle got %0b exp 1", dma_req_a); end
    checks++; if (ep_ack_a !== 16'h0) begin errors++; $display("FAIL single_noack got %0h exp 0", ep_ack_a); end
    next_cyc();
    checks++; if (dma_req_a !== 1'b0) begin errors++; $display("FAIL single_release got %0b exp 0", dma_req_a); end
    checks++; if (dma_ep_a !== 4'd2) begin errors++; $display("FAIL single_ep_hold got %0d exp 2", dma_ep_a); end
    next_cyc();
    checks++; if (dma_req_a !== 1'b0) begin errors++; $display("FAIL single_idle got %0b exp 0", dma_req_a); end
  endtask

  task automatic test_stray();
    ack_a = 1'b1;
    #1;
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL stray_err got %0b exp 1", err_a); end
    checks++; if (ep_ack_a !== 16'h0) begin errors++; $display("FAIL stray_ep_ack got %0h exp 0", ep_ack_a); end
    next_cyc();
    ack_a = 1'b0;
    #1;
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL stray_err_clear got %0b exp 0", err_a); end
    checks++; if (dma_req_a !== 1'b0) begin errors++; $display("FAIL stray_no_grant got %0b exp 0", dma_req_a); end
  endtask

  task automatic test_round_robin();
    int          order[4] = '{1, 5, 9, 1};
    logic [15:0] e;
    bit          seen;
    next_cyc();
    req_b = 16'h0222;
    for (int g = 0; g < 4; g++) begin
      e = 16'h0001 << order[g];
      wait_grant_b(8, seen);
      checks++; if (!seen) begin errors++; $display("FAIL rr_grant%0d got no grant exp dma_req=1", g); end
      checks++; if (dma_ep_b !== 4'(order[g])) begin errors++; $display("FAIL rr_ep%0d got %0d exp %0d", g, dma_ep_b, order[g]); end
      ack_b = 1'b1;
      #1;
      checks++; if (ep_ack_b !== e) begin errors++; $display("FAIL rr_ack1_%0d got %0h exp %0h", g, ep_ack_b, e); end
      next_cyc();
      ack_b = 1'b1;
      #1;
      checks++; if (ep_ack_b !== e) begin errors++; $display("FAIL rr_ack2_%0d got %0h exp %0h", g, ep_ack_b, e); end
      next_cyc();
      ack_b = 1'b0;
      #1;
      checks++; if (dma_req_b !== 1'b0) begin errors++; $display("FAIL rr_burst_release%0d got %0b exp 0", g, dma_req_b); end
    end
    next_cyc();
    req_b = 16'h0000;
  endtask

  task automatic test_wrap();
    bit seen;
    next_cyc();
    req_b = 16'h8000;
    wait_grant_b(6, seen);
    checks++; if (!seen || dma_ep_b !== 4'd15) begin errors++; $display("FAIL wrap_setup got seen=%0b ep=%0d exp 1/15", seen, dma_ep_b); end
    req_b = 16'h0000;
    next_cyc();
    checks++; if (dma_req_b !== 1'b0) begin errors++; $display("FAIL wrap_release got %0b exp 0", dma_req_b); end
    req_b = 16'h8001;
    wait_grant_b(6, seen);
    checks++; if (!seen) begin errors++; $display("FAIL wrap_grant got no grant exp dma_req=1"); end
    checks++; if (dma_ep_b !== 4'd0) begin errors++; $display("FAIL wrap_ep got %0d exp 0", dma_ep_b); end
    req_b = 16'h0000;
    next_cyc();
    next_cyc();
  endtask

  task automatic test_simultaneous();
    bit seen;
    req_b = 16'h0008;
    wait_grant_b(6, seen);
    checks++; if (!seen || dma_ep_b !== 4'd3) begin errors++; $display("FAIL simul_grant got seen=%0b ep=%0d exp 1/3", seen, dma_ep_b); end
    ack_b = 1'b1; req_b = 16'h0000;
    #1;
    checks++; if (ep_ack_b !== 16'h0008) begin errors++; $display("FAIL simul_ack_fwd got %0h exp 0008", ep_ack_b); end
    next_cyc();
    ack_b = 1'b0;
    #1;
    checks++; if (dma_req_b !== 1'b0) begin errors++; $display("FAIL simul_release got %0b exp 0", dma_req_b); end
    next_cyc();
    req_b = 16'h0008;
    wait_grant_b(6, seen);
    checks++; if (!seen || dma_ep_b !== 4'd3) begin errors++; $display("FAIL simul_regrant got seen=%0b ep=%0d exp 1/3", seen, dma_ep_b); end
    ack_b = 1'b1;
    #1;
    checks++; if (ep_ack_b !== 16'h0008) begin errors++; $display("FAIL simul_ack_a got %0h exp 0008", ep_ack_b); end
    next_cyc();
    ack_b = 1'b0;
    #1;
    checks++; if (dma_req_b !== 1'b1) begin errors++; $display("FAIL simul_count_fresh got %0b exp 1", dma_req_b); end
    next_cyc();
    ack_b = 1'b1;
    #1;
    checks++; if (ep_ack_b !== 16'h0008) begin errors++; $display("FAIL simul_ack_b got %0h exp 0008", ep_ack_b); end
    next_cyc();
    ack_b = 1'b0;
    #1;
    checks++; if (dma_req_b !== 1'b0) begin errors++; $display("FAIL simul_burst_release got %0b exp 0", dma_req_b); end
    req_b = 16'h0000;
    next_cyc();
  endtask

  task automatic test_reset_mid();
    bit seen;
    next_cyc();
    req_a = 16'h0008;
    wait_grant_a(6, seen);
    checks++; if (!seen || dma_ep_a !== 4'd3) begin errors++; $display("FAIL rmid_grant got seen=%0b ep=%0d exp 1/3", seen, dma_ep_a); end
    ack_a = 1'b1;
    #1;
    checks++; if (ep_ack_a !== 16'h0008) begin errors++; $display("FAIL rmid_ack got %0h exp 0008", ep_ack_a); end
    rst = 1'b1;
    #1;
    checks++; if (dma_req_a !== 1'b0) begin errors++; $display("FAIL rmid_dma_req got %0b exp 0", dma_req_a); end
    checks++; if (ep_ack_a !== 16'h0) begin errors++; $display("FAIL rmid_ep_ack got %0h exp 0", ep_ack_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rmid_err got %0b exp 0", err_a); end
    checks++; if (dma_ep_a !== 4'd0) begin errors++; $display("FAIL rmid_dma_ep got %0d exp 0", dma_ep_a); end
    ack_a = 1'b0;
    next_cyc();
    rst = 1'b0;
    req_a = 16'h0009;
    wait_grant_a(6, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rmid_regrant got no grant exp dma_req=1"); end
    checks++; if (dma_ep_a !== 4'd0) begin errors++; $display("FAIL rmid_priority got %0d exp 0", dma_ep_a); end
    req_a = 16'h0000;
    next_cyc();
    next_cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_stray();
    test_round_robin();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
